// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT pipeline stages.
package fft_pkg;

    localparam int DATA_W = 25;
    localparam int TW_W   = 18;

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } cplx_data_t;

    typedef struct packed {
        logic signed [TW_W-1:0] re;
        logic signed [TW_W-1:0] im;
    } cplx_tw_t;

    typedef enum logic [1:0] {
        FILL,
        RUN,
        FLUSH
    } bf_state_t;

    // Halved butterfly leg: (a +/- b) >>> 1 per component.
    // Uses one guard bit, then drops the LSB (truncation, no rounding).
    function automatic cplx_data_t bf_half(cplx_data_t a, cplx_data_t b, logic sub);
        logic signed [DATA_W:0] re_w;
        logic signed [DATA_W:0] im_w;
        if (sub) begin
            re_w = {a.re[DATA_W-1], a.re} - {b.re[DATA_W-1], b.re};
            im_w = {a.im[DATA_W-1], a.im} - {b.im[DATA_W-1], b.im};
        end else begin
            re_w = {a.re[DATA_W-1], a.re} + {b.re[DATA_W-1], b.re};
            im_w = {a.im[DATA_W-1], a.im} + {b.im[DATA_W-1], b.im};
        end
        bf_half.re = re_w[DATA_W:1];
        bf_half.im = im_w[DATA_W:1];
    endfunction

endpackage

// File: rtl/twiddle_rom.sv
// Combinational twiddle table: entry m = exp(-j*2*pi*m/FFT_N) in Q1.17,
// FFT_N/2 entries, computed at elaboration time.
module twiddle_rom
    import fft_pkg::*;
#(
    parameter int FFT_N = 1024
) (
    input  logic [$clog2(FFT_N/2)-1:0] addr,
    output cplx_tw_t                   tw
);

    localparam int HALF  = FFT_N / 2;
    localparam int TW_MAX = (1 << (TW_W - 1)) - 1;

    function automatic int round_clamp(real x);
        int r;
        if (x >= 0.0) r = $rtoi(x + 0.5);
        else          r = -$rtoi(-x + 0.5);
        if (r >  TW_MAX) r =  TW_MAX;
        if (r < -TW_MAX) r = -TW_MAX;
        return r;
    endfunction

    function automatic cplx_tw_t tw_entry(int m, int n);
        real ang;
        int  c;
        int  s;
        ang = 2.0 * 3.14159265358979323846 * real'(m) / real'(n);
        c   = round_clamp( 131072.0 * $cos(ang));
        s   = round_clamp(-131072.0 * $sin(ang));
        tw_entry.re = TW_W'(c);
        tw_entry.im = TW_W'(s);
    endfunction

    cplx_tw_t rom [HALF];

    for (genvar m = 0; m < HALF; m++) begin : g_entry
        localparam cplx_tw_t ENTRY = tw_entry(m, FFT_N);
        assign rom[m] = ENTRY;
    end

    assign tw = rom[addr];

endmodule

// File: rtl/bf_sdf_stage.sv
// Radix-2 DIF single-path delay-feedback butterfly stage with a DELAY-deep
// feedback memory, twiddle lookup and FILL/RUN/FLUSH frame control.
module bf_sdf_stage
    import fft_pkg::*;
#(
    parameter int FFT_N = 1024,
    parameter int DELAY = 512
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [2*DATA_W-1:0] data_i,
    input  logic                data_valid_i,
    input  logic                flush_i,
    output logic [2*DATA_W-1:0] stage_o,
    output logic [2*TW_W-1:0]   w_o,
    output logic                data_valid_o,
    output logic                busy_o
);

    localparam int TW_STEP = FFT_N / (2 * DELAY);
    localparam int CNT_W   = $clog2(2 * DELAY);
    localparam int PTR_W   = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam int ADDR_W  = $clog2(FFT_N / 2);

    bf_state_t         state;
    logic [CNT_W-1:0]  cnt;
    logic [PTR_W-1:0]  ptr;
    cplx_data_t        mem [DELAY];

    logic              step;
    logic              phase_b;
    logic              out_en;
    logic [PTR_W-1:0]  k;
    cplx_data_t        in_sample;
    cplx_data_t        mem_rd;
    cplx_data_t        out_data;
    cplx_data_t        wr_data;
    logic [ADDR_W-1:0] tw_addr;
    cplx_tw_t          tw;

    twiddle_rom #(
        .FFT_N (FFT_N)
    ) u_rom (
        .addr (tw_addr),
        .tw   (tw)
    );

    // Decode the current processing step: butterfly legs, memory write-back and twiddle address.
    always_comb begin
        step      = (state == FLUSH) ? 1'b1 : data_valid_i;
        in_sample = (state == FLUSH) ? '0 : cplx_data_t'(data_i);
        phase_b   = cnt[CNT_W-1];
        k         = cnt[PTR_W-1:0];
        mem_rd    = mem[ptr];
        out_en    = step && (state != FILL);
        out_data  = mem_rd;
        wr_data   = in_sample;
        tw_addr   = '0;
        if (phase_b) begin
            out_data = bf_half(mem_rd, in_sample, 1'b0);
            wr_data  = bf_half(mem_rd, in_sample, 1'b1);
        end else begin
            tw_addr = ADDR_W'(int'(k) * TW_STEP);
        end
    end

    // Feedback memory: first-half samples in phase A, differences in phase B; never reset.
    always_ff @(posedge clk_i) begin
        if (rst_ni && step) begin
            mem[ptr] <= wr_data;
        end
    end

    // Frame FSM, step counter, pointer and registered outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state        <= FILL;
            cnt          <= '0;
            ptr          <= '0;
            data_valid_o <= 1'b0;
            busy_o       <= 1'b0;
            stage_o      <= '0;
            w_o          <= '0;
        end else begin
            data_valid_o <= out_en;
            if (out_en) begin
                stage_o <= out_data;
                w_o     <= tw;
            end
            if (step) begin
                cnt <= cnt + CNT_W'(1);
                ptr <= (ptr == PTR_W'(DELAY - 1)) ? '0 : ptr + PTR_W'(1);
            end
            unique case (state)
                FILL: begin
                    if (step && cnt == CNT_W'(DELAY - 1)) state <= RUN;
                end
                RUN: begin
                    if (flush_i && !data_valid_i && cnt == '0) begin
                        state  <= FLUSH;
                        busy_o <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (cnt == CNT_W'(DELAY - 1)) begin
                        state  <= FILL;
                        cnt    <= '0;
                        busy_o <= 1'b0;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_bf_sdf_stage.sv
// Self-checking bench for bf_sdf_stage (FFT_N=4, DELAY=2): a directed
// cycle table followed by random frames checked against a frame-level model.
module tb_bf_sdf_stage;

    localparam int N    = 4;
    localparam int D    = 2;
    localparam int STEP = N / (2 * D);

    // exp(-j*2*pi*m/4) in Q1.17, clamped to +/-(2^17-1): m=0 -> (1,0), m=1 -> (0,-1)
    localparam logic [35:0] W0 = {18'h1FFFF, 18'h00000};
    localparam logic [35:0] W1 = {18'h00000, 18'h20001};

    localparam int PMAX = (1 << 24) - 1;
    localparam int NMIN = -(1 << 24);

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [49:0] data_i;
    logic        data_valid_i;
    logic        flush_i;
    logic [49:0] stage_o;
    logic [35:0] w_o;
    logic        data_valid_o;
    logic        busy_o;

    int n_vec = 0;
    int n_err = 0;

    bf_sdf_stage #(
        .FFT_N (N),
        .DELAY (D)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .data_i       (data_i),
        .data_valid_i (data_valid_i),
        .flush_i      (flush_i),
        .stage_o      (stage_o),
        .w_o          (w_o),
        .data_valid_o (data_valid_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst_n;
        bit          dv;
        bit          fl;
        int          re;
        int          im;
        bit          ev;
        bit          eb;
        int          ere;
        int          eim;
        logic [35:0] ew;
    } vec_t;

    typedef struct {
        logic [49:0] st;
        logic [35:0] w;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    exp_t sb_e;
    bit   sb_en = 1'b0;

    function automatic vec_t mk(bit rst_n, bit dv, bit fl, int re, int im,
                                bit ev, bit eb, int ere, int eim, logic [35:0] ew);
        vec_t v;
        v.rst_n = rst_n; v.dv = dv; v.fl = fl; v.re = re; v.im = im;
        v.ev = ev; v.eb = eb; v.ere = ere; v.eim = eim; v.ew = ew;
        return v;
    endfunction

    function automatic logic [49:0] pack(int re, int im);
        return {25'(re), 25'(im)};
    endfunction

    function automatic logic [35:0] tw_ref(int m);
        return (m == 0) ? W0 : W1;
    endfunction

    task automatic applyStimulus(input bit rst_n, input bit dv, input bit fl, input int re, input int im);
        rst_ni       = rst_n;
        data_valid_i = dv;
        flush_i      = fl;
        data_i       = pack(re, im);
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Scoreboard: every output pulse in the random phase must match the next model entry.
    always @(negedge clk) begin
        if (sb_en && data_valid_o) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("[TB] FAIL unexpected output: got %h / %h, expected none", stage_o, w_o);
            end else begin
                sb_e = exp_q.pop_front();
                checkOutput("rand stage", 64'(stage_o), 64'(sb_e.st));
                checkOutput("rand w",     64'(w_o),     64'(sb_e.w));
            end
        end
    end

    initial begin
        int x_re[2*D];
        int x_im[2*D];
        int d_re[D];
        int d_im[D];
        bit primed;
        exp_t e;

        // rst, dv, fl, in_re, in_im, exp valid, exp busy, exp re, exp im, exp w
        vecs.push_back(mk(0,0,0,   0,0,   0,0,    0,0,    36'd0));
        vecs.push_back(mk(0,0,0,   0,0,   0,0,    0,0,    36'd0));
        // first frame: only phase B produces sums
        vecs.push_back(mk(1,1,0, 100,0,   0,0,    0,0,    36'd0));
        vecs.push_back(mk(1,1,0, 200,0,   0,0,    0,0,    36'd0));
        vecs.push_back(mk(1,1,0, 300,0,   1,0,  200,0,    W0));
        vecs.push_back(mk(1,1,0, 400,0,   1,0,  300,0,    W0));
        // flush drains the two stored differences
        vecs.push_back(mk(1,0,1,   0,0,   0,1,  300,0,    W0));
        vecs.push_back(mk(1,0,0,   0,0,   1,1, -100,0,    W0));
        vecs.push_back(mk(1,0,0,   0,0,   1,0, -100,0,    W1));
        vecs.push_back(mk(1,0,0,   0,0,   0,0, -100,0,    W1));
        // back in FILL: new frame, outputs held while idle
        vecs.push_back(mk(1,1,0,   1,0,   0,0, -100,0,    W1));
        vecs.push_back(mk(1,1,0,   2,0,   0,0, -100,0,    W1));
        vecs.push_back(mk(1,1,0,   3,0,   1,0,    2,0,    W0));
        vecs.push_back(mk(1,1,0,   4,0,   1,0,    3,0,    W0));
        // flush with valid, and flush at cnt=1, are ignored
        vecs.push_back(mk(1,1,1,  10,0,   1,0,   -1,0,    W0));
        vecs.push_back(mk(1,0,1,   0,0,   0,0,   -1,0,    W0));
        vecs.push_back(mk(1,1,0,  20,0,   1,0,   -1,0,    W1));
        vecs.push_back(mk(1,1,0,  30,0,   1,0,   20,0,    W0));
        vecs.push_back(mk(1,1,0,  40,0,   1,0,   30,0,    W0));
        // back-to-back frame: previous differences come out without a gap
        vecs.push_back(mk(1,1,0,   5,0,   1,0,  -10,0,    W0));
        vecs.push_back(mk(1,1,0,   6,0,   1,0,  -10,0,    W1));
        vecs.push_back(mk(1,1,0,   7,0,   1,0,    6,0,    W0));
        vecs.push_back(mk(1,1,0,   8,0,   1,0,    7,0,    W0));
        // reset in the middle of a flush
        vecs.push_back(mk(1,0,1,   0,0,   0,1,    7,0,    W0));
        vecs.push_back(mk(1,0,0,   0,0,   1,1,   -1,0,    W0));
        vecs.push_back(mk(0,0,0,   0,0,   0,0,    0,0,    36'd0));
        vecs.push_back(mk(1,1,0, 100,0,   0,0,    0,0,    36'd0));
        vecs.push_back(mk(1,1,0, 200,0,   0,0,    0,0,    36'd0));
        vecs.push_back(mk(1,1,0, 300,0,   1,0,  200,0,    W0));
        vecs.push_back(mk(1,1,0, 400,0,   1,0,  300,0,    W0));
        // full-scale inputs: sum truncates to -1, differences reach the rails
        vecs.push_back(mk(1,1,0, PMAX,NMIN, 1,0, -100,0,  W0));
        vecs.push_back(mk(1,1,0,   0,0,     1,0, -100,0,  W1));
        vecs.push_back(mk(1,1,0, NMIN,PMAX, 1,0,   -1,-1, W0));
        vecs.push_back(mk(1,1,0,   0,0,     1,0,    0,0,  W0));
        vecs.push_back(mk(1,0,1,   0,0,     0,1,    0,0,  W0));
        vecs.push_back(mk(1,0,0,   0,0,     1,1, PMAX,NMIN, W0));
        vecs.push_back(mk(1,0,0,   0,0,     1,0,    0,0,  W1));
        vecs.push_back(mk(1,0,0,   0,0,     0,0,    0,0,  W1));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst_n, vecs[i].dv, vecs[i].fl, vecs[i].re, vecs[i].im);
            @(posedge clk);
            #1;
            checkOutput($sformatf("row%0d valid", i), 64'(data_valid_o), 64'(vecs[i].ev));
            checkOutput($sformatf("row%0d busy", i),  64'(busy_o),       64'(vecs[i].eb));
            checkOutput($sformatf("row%0d stage", i), 64'(stage_o),      64'(pack(vecs[i].ere, vecs[i].eim)));
            checkOutput($sformatf("row%0d w", i),     64'(w_o),          64'(vecs[i].ew));
            @(negedge clk);
        end

        // random frames against the frame-level model
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        sb_en  = 1'b1;
        primed = 1'b0;
        for (int f = 0; f < 40; f++) begin
            for (int s = 0; s < 2*D; s++) begin
                x_re[s] = int'($urandom_range(0, (1 << 25) - 1)) - (1 << 24);
                x_im[s] = int'($urandom_range(0, (1 << 25) - 1)) - (1 << 24);
            end
            if (primed) begin
                for (int kk = 0; kk < D; kk++) begin
                    e.st = pack(d_re[kk], d_im[kk]);
                    e.w  = tw_ref(kk * STEP);
                    exp_q.push_back(e);
                end
            end
            for (int kk = 0; kk < D; kk++) begin
                e.st = pack((x_re[kk] + x_re[kk+D]) >>> 1, (x_im[kk] + x_im[kk+D]) >>> 1);
                e.w  = W0;
                exp_q.push_back(e);
                d_re[kk] = (x_re[kk] - x_re[kk+D]) >>> 1;
                d_im[kk] = (x_im[kk] - x_im[kk+D]) >>> 1;
            end
            primed = 1'b1;
            for (int s = 0; s < 2*D; s++) begin
                repeat ($urandom_range(0, 2)) begin
                    applyStimulus(1, 0, (s != 0) ? 1'($urandom_range(0, 1)) : 1'b0,
                                  int'($urandom), int'($urandom));
                    @(negedge clk);
                end
                applyStimulus(1, 1, 1'($urandom_range(0, 1)), x_re[s], x_im[s]);
                @(negedge clk);
            end
            if ($urandom_range(0, 3) == 0) begin
                for (int kk = 0; kk < D; kk++) begin
                    e.st = pack(d_re[kk], d_im[kk]);
                    e.w  = tw_ref(kk * STEP);
                    exp_q.push_back(e);
                end
                primed = 1'b0;
                applyStimulus(1, 0, 1, 0, 0);
                @(negedge clk);
                repeat (D + 1) begin
                    applyStimulus(1, 0, 1'($urandom_range(0, 1)), 0, 0);
                    @(negedge clk);
                end
            end
        end
        applyStimulus(1, 0, 0, 0, 0);
        repeat (4) @(negedge clk);
        checkOutput("scoreboard drained", 64'(exp_q.size()), 64'd0);
        sb_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bf_sdf_stage.md
BF_SDF_STAGE -- requirements
Module: bf_sdf_stage

Interface
REQ-001 SHALL have parameter FFT_N, default 1024: transform length, a power of 2 from 4 to 4096.
REQ-002 SHALL have parameter DELAY, default 512: feedback depth, a power of 2 from 1 to FFT_N/2.
REQ-003 SHALL have localparam TW_STEP = FFT_N/(2*DELAY): the twiddle address stride.
REQ-004 SHALL have the following ports, clock and reset first:
- clk_i  in  1: the single clock.
- rst_ni  in  1: reset, synchronous, active-low.
- data_i  in  50: complex sample {re[24:0], im[24:0]}, two's complement.
- data_valid_i  in  1: data_i is valid this cycle.
- flush_i  in  1: request to drain the stored differences of the last frame.
- stage_o  out  50: butterfly result {re, im}, feeds the multiplier data input.
- w_o  out  36: twiddle {re[17:0], im[17:0]}, Q1.17, aligned with stage_o.
- data_valid_o  out  1: stage_o and w_o are valid.
- busy_o  out  1: high while in FLUSH.

Function
REQ-005 SHALL implement a radix-2 DIF single-path delay-feedback butterfly with a DELAY-entry feedback memory.
- Memory is a circular buffer with a single pointer.
- The pointer advances only on a processing step, i.e. an accepted input or an internal flush step.
REQ-006 SHALL keep a sample counter cnt of log2(2*DELAY) bits, incremented on every processing step.
- cnt wraps to 0 after 2*DELAY-1.
- Phase A is cnt < DELAY; phase B is cnt >= DELAY.
REQ-007 In phase A, each step SHALL:
- write the input to the memory;
- output the previously stored difference with twiddle address k*TW_STEP, where k = cnt mod DELAY.
REQ-008 In phase B, each step SHALL:
- output sum = (mem + in) >>> 1 with twiddle address 0;
- write diff = (mem - in) >>> 1 back to the memory.
REQ-009 Arithmetic SHALL be done per component at 26 bits.
- Then an arithmetic right shift by 1 and truncation to 25 bits.
- No rounding; no saturation needed.
REQ-010 Twiddle entry m SHALL equal round(2^17*cos(2*pi*m/FFT_N)) and round(-2^17*sin(2*pi*m/FFT_N)).
- Both components are clamped to the range ±(2^17-1).
REQ-011 stage_o, w_o and data_valid_o SHALL be registered, giving a latency of exactly 1 cycle from the processing step.
- data_valid_o is high for one cycle per output sample.
REQ-012 stage_o and w_o SHALL hold their last value while data_valid_o is low.
REQ-013 FSM states SHALL be FILL, RUN and FLUSH.
REQ-014 In FILL:
- phase A steps store input and produce no output, because the memory holds no valid differences;
- the transition to phase B (cnt reaches DELAY) moves the FSM to RUN.
REQ-015 In RUN, all steps produce output.
- flush_i is honoured only when cnt == 0 and data_valid_i == 0; then the FSM enters FLUSH.
- flush_i at any other time is ignored.
REQ-016 In FLUSH, the block SHALL generate one internal step per cycle, DELAY steps in total.
- Input is treated as zero and only the phase A output is produced.
- After the last step, cnt == 0 and the FSM moves to FILL.
REQ-017 data_valid_i and flush_i SHALL be ignored while in FLUSH, and the upstream does not send data then.
REQ-018 With DELAY == 1, phases SHALL alternate every step and the twiddle address SHALL always be 0.

Reset
REQ-019 rst_ni low at a clock edge SHALL reset the block as follows:
- FSM to FILL and cnt to 0;
- pointer to 0;
- data_valid_o, busy_o, stage_o and w_o to 0.
REQ-020 Memory contents SHALL NOT be reset.
REQ-021 Reset mid-frame or mid-flush SHALL discard the frame with no further output.

Structure
REQ-022 A shared package fft_pkg SHALL hold:
- cplx_data_t (25+25);
- cplx_tw_t (18+18);
- DATA_W = 25 and TW_W = 18;
- the bf_state_t enum.
REQ-023 The sub-module twiddle_rom SHALL be a combinational lookup of FFT_N/2 entries, parameterised by FFT_N and filled at elaboration.
REQ-024 The feedback memory SHALL be inline, as a distributed or BRAM-inferable array.

Verification
REQ-025 The bench SHALL use FFT_N=4, DELAY=2 and cover these scenarios:
- Reset, then inputs re 100, 200, 300, 400 with im 0 on consecutive cycles -> outputs (200,0) and (300,0), each with w_o = {18'h1FFFF, 18'h00000}, at 1-cycle latency.
- Then flush_i for one cycle -> busy_o high for 2 cycles; outputs (-100,0) with W0, then (-100,0) with w_o = {18'h00000, 18'h20001}; FSM returns to FILL.
- Back-to-back frames with no flush -> the second frame's phase A outputs the first frame's differences; there is no gap in data_valid_o.
- flush_i asserted mid-frame (cnt=1), or together with data_valid_i -> ignored; busy_o stays 0.
- rst_ni low during FLUSH -> data_valid_o is 0 from the next cycle; a new frame then behaves as in the first scenario.
- Inputs re 2^24-1 and -2^24 -> no overflow; sum = -1 (truncation), diff = 2^24-1.
